// File: rtl/bt_pipe_out_arbiter_if.sv
// Bundle of source-FIFO, host-pipe and status signals shared by bt_pipe_out_arbiter.
// master = arbiter side, slave = source/host side.
interface bt_pipe_out_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int LEVEL_W = 16
);
    logic [NUM_SRC-1:0]         src_enable;
    logic [NUM_SRC*LEVEL_W-1:0] src_level;
    logic [NUM_SRC*32-1:0]      src_data;
    logic [NUM_SRC-1:0]         src_rd;
    logic                       pipe_out_read;
    logic [31:0]                pipe_out_data;
    logic                       pipe_out_ready;
    logic [2:0]                 grant_id;
    logic [31:0]                block_count;
    logic                       overrun;

    modport master (
        input  src_enable, src_level, src_data, pipe_out_read,
        output src_rd, pipe_out_data, pipe_out_ready, grant_id, block_count, overrun
    );

    modport slave (
        output src_enable, src_level, src_data, pipe_out_read,
        input  src_rd, pipe_out_data, pipe_out_ready, grant_id, block_count, overrun
    );
endinterface

// File: rtl/bt_pipe_out_arbiter.sv
// Block-granular round-robin arbiter sharing one BTPipeOut endpoint between FWFT source FIFOs.
// Optional macro ARB_HEADER_EN: prepend a header word to each block and lower the eligibility threshold by one.
//
// state  | meaning
// IDLE   | first cycle after reset
// SELECT | round-robin scan for a source holding a full block
// ARMED  | pipe_out_ready high, host reads the granted source's block
module bt_pipe_out_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int LEVEL_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bt_pipe_out_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(BLOCK_WORDS);
`ifdef ARB_HEADER_EN
    localparam int THRESH_I = BLOCK_WORDS - 1;
`else
    localparam int THRESH_I = BLOCK_WORDS;
`endif
    localparam logic [LEVEL_W-1:0] THRESH = LEVEL_W'(THRESH_I);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SELECT, ARMED} state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        blk_q, blk_d;
    logic               ovr_q, ovr_d;

    logic [NUM_SRC-1:0] eligible;
    logic               armed_rd;
    logic               pop;
    logic               found;
    logic [31:0]        head_word;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = bus.src_enable[i] && (bus.src_level[i*LEVEL_W +: LEVEL_W] >= THRESH);
        end
    end

    assign armed_rd = bus.pipe_out_read && (state_q == ARMED);

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ovr_d   = ovr_q;
        found   = 1'b0;
        case (state_q)
            IDLE: state_d = SELECT;
            SELECT: begin
                // Two passes give the wrap-around order ptr+1 .. NUM_SRC-1, 0 .. ptr.
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!found && eligible[i] && (i > int'(ptr_q))) begin
                        found   = 1'b1;
                        grant_d = 3'(i);
                        ptr_d   = 3'(i);
                    end
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!found && eligible[i] && (i <= int'(ptr_q))) begin
                        found   = 1'b1;
                        grant_d = 3'(i);
                        ptr_d   = 3'(i);
                    end
                end
                if (found) begin
                    state_d = ARMED;
                    ready_d = 1'b1;
                end
            end
            ARMED: begin
                if (armed_rd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        blk_d   = blk_q + 32'd1;
                        ready_d = 1'b0;
                        state_d = SELECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.pipe_out_read && (state_q != ARMED)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        head_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                head_word = bus.src_data[i*32 +: 32];
            end
        end
    end

`ifdef ARB_HEADER_EN
    assign pop = armed_rd && (cnt_q != '0);
    assign bus.pipe_out_data = (state_q != ARMED) ? 32'd0 :
                               (cnt_q == '0) ? {8'hA5, 5'd0, grant_q, blk_q[15:0]} : head_word;
`else
    assign pop = armed_rd;
    assign bus.pipe_out_data = (state_q == ARMED) ? head_word : 32'd0;
`endif

    always_comb begin
        bus.src_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_rd[i] = pop && (grant_q == 3'(i));
        end
    end

    assign bus.pipe_out_ready = ready_q;
    assign bus.grant_id       = grant_q;
    assign bus.block_count    = blk_q;
    assign bus.overrun        = ovr_q;
endmodule

// File: tb/tb_bt_pipe_out_arbiter.sv
// Self-checking bench for bt_pipe_out_arbiter: block-level reference model, directed scenarios, random traffic.
module tb_bt_pipe_out_arbiter;
    localparam int N  = 4;
    localparam int BW = 4;
    localparam int LW = 16;
`ifdef ARB_HEADER_EN
    localparam int THR = BW - 1;
    localparam bit HDR = 1'b1;
`else
    localparam int THR = BW;
    localparam bit HDR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bt_pipe_out_arbiter_if #(.NUM_SRC(N), .LEVEL_W(LW)) bus ();

    bt_pipe_out_arbiter #(.NUM_SRC(N), .BLOCK_WORDS(BW), .LEVEL_W(LW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Source FIFOs: fill level and current head word per source.
    int          lvl[N];
    logic [31:0] hd[N];
    logic [N-1:0] en;
    logic        rd;

    // Reference model: phase 0 = just out of reset, 1 = choosing, 2 = serving a block.
    int          m_phase, m_grant, m_ptr, m_words;
    logic [31:0] m_blocks;
    logic        m_ovr;

    logic         s_ready, s_ovr;
    logic [31:0]  s_data, s_bc;
    logic [N-1:0] s_rd;
    logic [2:0]   s_grant;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.src_enable    = en;
        bus.pipe_out_read = rd;
        for (int i = 0; i < N; i++) begin
            bus.src_level[i*LW +: LW] = lvl[i][LW-1:0];
            bus.src_data[i*32 +: 32]  = hd[i];
        end
    endtask

    function automatic logic header_word_now();
        return HDR && (m_words == 0);
    endfunction

    function automatic logic [31:0] exp_data();
        if (m_phase != 2) return 32'd0;
        if (header_word_now()) return {8'hA5, 5'd0, 3'(m_grant), m_blocks[15:0]};
        return hd[m_grant];
    endfunction

    function automatic logic [N-1:0] exp_rd();
        if (m_phase == 2 && rd && !header_word_now()) return N'(1 << m_grant);
        return '0;
    endfunction

    task automatic compare_all();
        s_ready = bus.pipe_out_ready;
        s_data  = bus.pipe_out_data;
        s_rd    = bus.src_rd;
        s_grant = bus.grant_id;
        s_bc    = bus.block_count;
        s_ovr   = bus.overrun;
        check("ready",  32'(s_ready), 32'(m_phase == 2));
        check("data",   s_data, exp_data());
        check("src_rd", 32'(s_rd), 32'(exp_rd()));
        check("grant",  32'(s_grant), 32'(m_grant));
        check("blocks", s_bc, m_blocks);
        check("overrun", 32'(s_ovr), 32'(m_ovr));
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic step();
        if (m_phase == 2 && rd && !header_word_now()) begin
            lvl[m_grant]--;
            hd[m_grant]++;
        end
        if (reset) begin
            m_phase = 0; m_grant = 0; m_ptr = 0; m_words = 0; m_blocks = 0; m_ovr = 1'b0;
        end else begin
            if (rd && m_phase != 2) m_ovr = 1'b1;
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    for (int k = 1; k <= N; k++) begin
                        int j;
                        j = (m_ptr + k) % N;
                        if (en[j] && (32'(lvl[j][LW-1:0]) >= THR)) begin
                            m_grant = j;
                            m_ptr   = j;
                            m_phase = 2;
                            break;
                        end
                    end
                end
                default: begin
                    if (rd) begin
                        m_words++;
                        if (m_words == BW) begin
                            m_words = 0;
                            m_blocks++;
                            m_phase = 1;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic tick(input logic r);
        rd = r;
        apply();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic serve(output int g, input int nwords);
        int n;
        n = 0;
        while (!bus.pipe_out_ready && n < 20) begin
            tick(1'b0);
            n++;
        end
        check("arm_wait", 32'(bus.pipe_out_ready), 32'd1);
        g = int'(bus.grant_id);
        for (int w = 0; w < nwords; w++) tick(1'b1);
    endtask

    initial begin
        int g, n_hi;
        int exp_g[8];
        exp_g = '{1, 2, 3, 0, 1, 2, 3, 0};
        en = '0; rd = 1'b0;
        for (int i = 0; i < N; i++) begin lvl[i] = 0; hd[i] = '0; end
        m_phase = 0; m_grant = 0; m_ptr = 0; m_words = 0; m_blocks = 0; m_ovr = 1'b0;

        // 1: nothing eligible, stray read sets overrun
        en = 4'hF;
        do_reset();
        n_hi = 0;
        repeat (50) begin tick(1'b0); n_hi += int'(s_ready); end
        check("t1_ready_hi", 32'(n_hi), 32'd0);
        tick(1'b1);
        check("t1_no_pop", 32'(s_rd), 32'd0);
        tick(1'b0);
        check("t1_overrun", 32'(s_ovr), 32'd1);
        check("t1_blocks", s_bc, 32'd0);

        // 2: single source, arming latency and data order
        en = 4'b0100; lvl[2] = 4; hd[2] = 32'h200;
        do_reset();
        tick(1'b0);
        tick(1'b0);
        check("t2_ready_pre", 32'(s_ready), 32'd0);
        check("t2_ready_up", 32'(bus.pipe_out_ready), 32'd1);
        for (int w = 0; w < 4; w++) begin
            tick(1'b1);
`ifndef ARB_HEADER_EN
            check("t2_data", s_data, 32'h200 + 32'(w));
            check("t2_src_rd", 32'(s_rd), 32'h4);
`endif
        end
        tick(1'b0);
        check("t2_ready_after", 32'(s_ready), 32'd0);
        check("t2_blocks", s_bc, 32'd1);

        // 3: round-robin over all four sources
        en = 4'hF;
        for (int i = 0; i < N; i++) begin lvl[i] = 8; hd[i] = 32'(i) << 8; end
        do_reset();
        for (int b = 0; b < 8; b++) begin
            serve(g, 4);
            check("t3_grant", 32'(g), 32'(exp_g[b]));
        end
        tick(1'b0);
        check("t3_blocks", s_bc, 32'd8);

        // 4: threshold boundary
        en = 4'b1010;
        for (int i = 0; i < N; i++) begin lvl[i] = 0; hd[i] = 32'(i) << 8; end
        lvl[1] = 3; lvl[3] = 4;
        do_reset();
        serve(g, 4);
        check("t4_first", 32'(g), HDR ? 32'd1 : 32'd3);
`ifndef ARB_HEADER_EN
        repeat (5) tick(1'b0);
        check("t4_level3_idle", 32'(bus.pipe_out_ready), 32'd0);
`endif
        lvl[1] = 4;
        serve(g, 4);
        check("t4_second", 32'(g), HDR ? 32'd3 : 32'd1);

        // 5: enable dropped mid-block
        en = 4'b0001;
        for (int i = 0; i < N; i++) begin lvl[i] = 0; hd[i] = '0; end
        lvl[0] = 8; hd[0] = 32'h400;
        do_reset();
        serve(g, 2);
        check("t5_grant0", 32'(g), 32'd0);
        en = 4'b0000;
        tick(1'b1);
        check("t5_data_cont", s_data, HDR ? 32'h401 : 32'h402);
        tick(1'b1);
        en = 4'b0010; lvl[1] = 4; hd[1] = 32'h110;
        serve(g, 4);
        check("t5_grant1", 32'(g), 32'd1);
        repeat (10) tick(1'b0);
        check("t5_src0_off", 32'(bus.pipe_out_ready), 32'd0);

        // 6: reset mid-block
        en = 4'b0001;
        for (int i = 0; i < N; i++) begin lvl[i] = 0; hd[i] = '0; end
        lvl[0] = 12; hd[0] = 32'h500;
        do_reset();
        serve(g, 4);
        serve(g, 2);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        check("t6_ready", 32'(s_ready), 32'd0);
        check("t6_blocks", s_bc, 32'd0);
        reset = 1'b0;
        serve(g, 1);
`ifndef ARB_HEADER_EN
        check("t6_new_head", s_data, 32'h506);
`endif

        // random traffic against the model
        en = 4'hF;
        for (int i = 0; i < N; i++) begin lvl[i] = int'($urandom_range(0, 9)); hd[i] = $urandom; end
        do_reset();
        repeat (400) begin
            if ($urandom_range(0, 19) == 0) en = N'($urandom);
            if ($urandom_range(0, 9) == 0) lvl[$urandom_range(0, N-1)] = int'($urandom_range(0, 9));
            tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
